store_merge_unit: RTL and testbench

Store-side counterpart to the load sign-extension path. It accepts a store request of byte, halfword or word size, and writes it into word-organised data memory. Byte and halfword stores use a read-modify-write sequence; word stores write directly. It sits between the execute/memory stage control and the data memory port, and reports completion or fault through a one-cycle response pulse.

---
 rtl/store_merge_unit.sv | 138 +++++++++++++
 tb/tb_store_merge_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// Sub-word store unit: byte/halfword stores do read-modify-write on a word-wide
// data memory, word stores write directly; completion or fault is a one-cycle pulse.
module store_merge_unit #(
  parameter int ACK_TIMEOUT = 16,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  localparam int CNT_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int TO_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);
  localparam bit TO_EN = (ACK_TIMEOUT > 0);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         data_q, data_d;
  logic [1:0]          size_q, size_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         merged;
  logic                fault;

  // Little-endian lane replacement; size_q is only byte or half when in RD.
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = data_q;
    end
  end

  assign fault = (req_size == 2'b11)
               | ((req_size == 2'b01) & req_addr[0])
               | ((req_size == 2'b10) & (|req_addr[1:0]));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          data_d = req_data[15:0];
          size_d = req_size;
          err_d  = 1'b0;
          cnt_d  = '0;
          if (fault) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_size == 2'b10) begin
            wdata_d = req_data;
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (mem_ack) begin
          wdata_d = merged;
          cnt_d   = '0;
          state_d = S_WR;
        end else if (TO_EN && (cnt_q == TO_LAST_C)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR: begin
        if (mem_ack) begin
          state_d = S_RESP;
        end else if (TO_EN && (cnt_q == TO_LAST_C)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign mem_rd     = (state_q == S_RD);
  assign mem_wr     = (state_q == S_WR);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = (state_q == S_RESP) & err_q;
  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: scoreboard queues hold expected writes and
// responses, a monitor pops them as the DUT presents them.
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        resp_valid, resp_err;
  logic [31:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_wr_q[$];
  logic        exp_resp_q[$];

  int rd_delay = 0;
  int wr_delay = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  store_merge_unit #(.ACK_TIMEOUT(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: ack after a programmable number of strobe cycles.
  always @(negedge clk) begin
    if (mem_rd) begin
      mem_ack = (rd_cnt >= rd_delay);
      rd_cnt++;
    end else if (mem_wr) begin
      mem_ack = (wr_cnt >= wr_delay);
      wr_cnt++;
    end else begin
      mem_ack = 1'b0;
    end
    if (!mem_rd) rd_cnt = 0;
    if (!mem_wr) wr_cnt = 0;
  end

  always @(negedge clk) begin
    #1;
    if (mem_wr && mem_ack) begin
      if (exp_wr_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_wr_q.pop_front();
        check("wr_addr", mem_addr, e[63:32]);
        check("wr_data", mem_wdata, e[31:0]);
        $display("write addr=0x%08h data=0x%08h", mem_addr, mem_wdata);
      end
    end
    if (resp_valid) begin
      if (exp_resp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic e;
        e = exp_resp_q.pop_front();
        check("resp_err", {31'd0, resp_err}, {31'd0, e});
        $display("resp err=%0b", resp_err);
      end
    end
  end

  task automatic do_store(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input logic [31:0] rdata,
                          input int rdd, input int wrd, input logic exp_err,
                          input logic do_wr, input logic [31:0] exp_wdata,
                          input int exp_lat, input int exp_rd, input int exp_wrc);
    int lat, nrd, nwr;
    exp_resp_q.push_back(exp_err);
    if (do_wr) exp_wr_q.push_back({addr & 32'hFFFF_FFFC, exp_wdata});
    rd_delay = rdd;
    wr_delay = wrd;
    mem_rdata = rdata;
    check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_addr = addr; req_data = data; req_size = size; req_valid = 1'b1;
    lat = 0; nrd = 0; nwr = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_rd) nrd++;
      if (mem_wr) nwr++;
      if (resp_valid) begin
        lat = cyc;
        break;
      end
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_rd_cycles"}, nrd, exp_rd);
    check({name, "_wr_cycles"}, nwr, exp_wrc);
    @(negedge clk);
    check({name, "_resp_one_cycle"}, {31'd0, resp_valid}, 32'd0);
    check({name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    $display("%s addr=0x%08h size=%0d latency=%0d rd=%0d wr=%0d", name, addr, size, lat, nrd, nwr);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);

    do_store("word",    32'h100, 32'hDEADBEEF, 2'b10, 32'h0,        0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 2, 0, 1);
    do_store("byte3",   32'h103, 32'hFFFFFFAB, 2'b00, 32'h11223344, 0, 0, 1'b0, 1'b1, 32'hAB223344, 3, 1, 1);
    do_store("byte0",   32'h100, 32'hFFFFFFAB, 2'b00, 32'h11223344, 0, 0, 1'b0, 1'b1, 32'h112233AB, 3, 1, 1);
    do_store("byte1",   32'h101, 32'h000000C5, 2'b00, 32'h11223344, 0, 0, 1'b0, 1'b1, 32'h1122C544, 3, 1, 1);
    do_store("half_hi", 32'h202, 32'h0000BEEF, 2'b01, 32'h11223344, 0, 0, 1'b0, 1'b1, 32'hBEEF3344, 3, 1, 1);
    do_store("half_lo", 32'h200, 32'h0000BEEF, 2'b01, 32'h11223344, 0, 0, 1'b0, 1'b1, 32'h1122BEEF, 3, 1, 1);
    do_store("flt_half", 32'h201, 32'h0000BEEF, 2'b01, 32'h0,       0, 0, 1'b1, 1'b0, 32'h0, 1, 0, 0);
    do_store("flt_word", 32'h102, 32'h12345678, 2'b10, 32'h0,       0, 0, 1'b1, 1'b0, 32'h0, 1, 0, 0);
    do_store("flt_rsvd", 32'h100, 32'h12345678, 2'b11, 32'h0,       0, 0, 1'b1, 1'b0, 32'h0, 1, 0, 0);
    do_store("to_rd",   32'h101, 32'h000000AA, 2'b00, 32'h11223344, 99, 0, 1'b1, 1'b0, 32'h0, 5, 4, 0);
    do_store("wr_slow", 32'h300, 32'hCAFEF00D, 2'b10, 32'h0,        0, 3, 1'b0, 1'b1, 32'hCAFEF00D, 5, 0, 4);

    // Abort a byte store with a one-cycle reset pulse while in RD.
    rd_delay = 99;
    req_addr = 32'h101; req_data = 32'h55; req_size = 2'b00; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_rd", {31'd0, mem_rd}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_rd_drop", {31'd0, mem_rd}, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    $display("abort done");
    do_store("post_rst", 32'h104, 32'h12345678, 2'b10, 32'h0, 0, 0, 1'b0, 1'b1, 32'h12345678, 2, 0, 1);

    repeat (2) @(negedge clk);
    check("exp_wr_drained", exp_wr_q.size(), 32'd0);
    check("exp_resp_drained", exp_resp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
